mem_bus_arbiter: RTL

Shares the single external memory bus between the instruction-cache line-fill port and the data-cache (MEM-stage) port. Grants one requester at a time, sequences instruction line fills as fixed-length incrementing bursts, and runs data accesses as single beats. Sits between both caches and the bus interface, and forwards bus errors to the granted requester (the data-side error feeds the MEM-stage `BUS_ERROR_SX` exception path).

---
 rtl/mem_bus_arbiter_if.sv | 53 +++++
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: groups the instruction-cache fill port, the data-cache
// port and the external memory bus seen by mem_bus_arbiter.
//   ICACHE_*_SI / DCACHE_*_SD : requests from the two caches
//   ICACHE_*_SA / DCACHE_*_SA : per-cache responses from the arbiter
//   BUS_*_SA                  : bus request driven by the arbiter
//   BUS_*_SX                  : bus completion (ready / read data / error)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (caches plus bus interface)
interface mem_bus_arbiter_if;
  logic        ICACHE_REQ_SI;
  logic [31:0] ICACHE_ADR_SI;
  logic        ICACHE_ACK_SA;
  logic        ICACHE_LAST_SA;
  logic [31:0] ICACHE_DATA_SA;
  logic        ICACHE_ERR_SA;

  logic        DCACHE_REQ_SD;
  logic        DCACHE_WE_SD;
  logic [31:0] DCACHE_ADR_SD;
  logic [31:0] DCACHE_DATA_SD;
  logic [3:0]  DCACHE_BYTSEL_SD;
  logic        DCACHE_ACK_SA;
  logic [31:0] DCACHE_DATA_SA;
  logic        DCACHE_ERR_SA;

  logic        BUS_VALID_SA;
  logic        BUS_WE_SA;
  logic [31:0] BUS_ADR_SA;
  logic [31:0] BUS_WDATA_SA;
  logic [3:0]  BUS_BYTSEL_SA;
  logic        BUS_READY_SX;
  logic [31:0] BUS_RDATA_SX;
  logic        BUS_ERROR_SX;

  modport slave (
    input  ICACHE_REQ_SI, ICACHE_ADR_SI,
    output ICACHE_ACK_SA, ICACHE_LAST_SA, ICACHE_DATA_SA, ICACHE_ERR_SA,
    input  DCACHE_REQ_SD, DCACHE_WE_SD, DCACHE_ADR_SD, DCACHE_DATA_SD, DCACHE_BYTSEL_SD,
    output DCACHE_ACK_SA, DCACHE_DATA_SA, DCACHE_ERR_SA,
    output BUS_VALID_SA, BUS_WE_SA, BUS_ADR_SA, BUS_WDATA_SA, BUS_BYTSEL_SA,
    input  BUS_READY_SX, BUS_RDATA_SX, BUS_ERROR_SX
  );

  modport master (
    output ICACHE_REQ_SI, ICACHE_ADR_SI,
    input  ICACHE_ACK_SA, ICACHE_LAST_SA, ICACHE_DATA_SA, ICACHE_ERR_SA,
    output DCACHE_REQ_SD, DCACHE_WE_SD, DCACHE_ADR_SD, DCACHE_DATA_SD, DCACHE_BYTSEL_SD,
    input  DCACHE_ACK_SA, DCACHE_DATA_SA, DCACHE_ERR_SA,
    input  BUS_VALID_SA, BUS_WE_SA, BUS_ADR_SA, BUS_WDATA_SA, BUS_BYTSEL_SA,
    output BUS_READY_SX, BUS_RDATA_SX, BUS_ERROR_SX
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the external memory bus between the I-cache
// line-fill port (fixed-length incrementing bursts) and the D-cache port
// (single beats). Data has priority; bus errors abort the transaction and
// are forwarded to the owner.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset
//   arb_if   - mem_bus_arbiter_if.slave (cache ports + bus)
// Parameters:
//   BURST_LEN - words per instruction line fill (power of 2, >= 1)
//   MAX_WAIT  - instruction starvation threshold (cycles)
// Optional feature macro: ARB_STARVE_GUARD_EN - lets a long-waiting
//   instruction request win over a simultaneous data request.
module mem_bus_arbiter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_bus_arbiter_if.slave arb_if
);

  localparam int unsigned   CW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BURST_LEN - 1);
  localparam logic [31:0]   ALIGN_MASK = ~((BURST_LEN * 32'd4) - 32'd1);

  if (BURST_LEN == 0 || (BURST_LEN & (BURST_LEN - 1)) != 0 || MAX_WAIT == 0) begin : g_bad_params
    $error("mem_bus_arbiter: BURST_LEN must be a power of 2 and MAX_WAIT >= 1");
  end

  typedef enum logic [1:0] {IDLE, I_XFER, D_XFER} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   adr_q, wdata_q;
  logic          we_q;
  logic [3:0]    bytsel_q;
  logic          last_beat, d_wins, i_act, d_act, xfer;

  assign last_beat = (cnt_q == LAST_BEAT);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_q;
  logic          starved;

  assign starved = (32'(wait_q) >= MAX_WAIT);

  // Saturates at MAX_WAIT; that is all the priority decision needs.
  always_ff @(posedge clk) begin
    if (!reset_n)
      wait_q <= '0;
    else if (state_q != I_XFER && state_d == I_XFER)
      wait_q <= '0;
    else if (arb_if.ICACHE_REQ_SI && state_q != I_XFER && !starved)
      wait_q <= wait_q + 1'b1;
  end

  assign d_wins = arb_if.DCACHE_REQ_SD && !(starved && arb_if.ICACHE_REQ_SI);
`else
  assign d_wins = arb_if.DCACHE_REQ_SD;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_wins)                    state_d = D_XFER;
        else if (arb_if.ICACHE_REQ_SI) state_d = I_XFER;
      end
      I_XFER: if (arb_if.BUS_READY_SX && (arb_if.BUS_ERROR_SX || last_beat)) state_d = IDLE;
      D_XFER: if (arb_if.BUS_READY_SX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on grant and burst beat counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      bytsel_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
      if (state_d == D_XFER) begin
        adr_q    <= arb_if.DCACHE_ADR_SD;
        we_q     <= arb_if.DCACHE_WE_SD;
        wdata_q  <= arb_if.DCACHE_DATA_SD;
        bytsel_q <= arb_if.DCACHE_BYTSEL_SD;
      end else if (state_d == I_XFER) begin
        adr_q    <= arb_if.ICACHE_ADR_SI & ALIGN_MASK;
        we_q     <= 1'b0;
        wdata_q  <= '0;
        bytsel_q <= '1;
      end
    end else if (state_q == I_XFER && arb_if.BUS_READY_SX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Outputs are qualified by reset_n so everything reads 0 while reset is held,
  // even in the cycle before the synchronous reset takes effect.
  assign i_act = reset_n && (state_q == I_XFER);
  assign d_act = reset_n && (state_q == D_XFER);
  assign xfer  = i_act || d_act;

  // Output logic
  always_comb begin
    arb_if.BUS_VALID_SA   = xfer;
    arb_if.BUS_WE_SA      = xfer && we_q;
    arb_if.BUS_ADR_SA     = xfer ? (adr_q + 32'({cnt_q, 2'b00})) : '0;
    arb_if.BUS_WDATA_SA   = xfer ? wdata_q  : '0;
    arb_if.BUS_BYTSEL_SA  = xfer ? bytsel_q : '0;

    arb_if.ICACHE_ACK_SA  = i_act && arb_if.BUS_READY_SX;
    arb_if.ICACHE_DATA_SA = arb_if.ICACHE_ACK_SA ? arb_if.BUS_RDATA_SX : '0;
    arb_if.ICACHE_ERR_SA  = arb_if.ICACHE_ACK_SA && arb_if.BUS_ERROR_SX;
    arb_if.ICACHE_LAST_SA = arb_if.ICACHE_ACK_SA && (last_beat || arb_if.BUS_ERROR_SX);

    arb_if.DCACHE_ACK_SA  = d_act && arb_if.BUS_READY_SX;
    arb_if.DCACHE_DATA_SA = arb_if.DCACHE_ACK_SA ? arb_if.BUS_RDATA_SX : '0;
    arb_if.DCACHE_ERR_SA  = arb_if.DCACHE_ACK_SA && arb_if.BUS_ERROR_SX;
  end

endmodule
